// File: rtl/if_prefetch_queue.sv
// Instruction-fetch front end: sequential PC generation, synchronous imem reads and a
// small prefetch FIFO feeding decode, with redirect flush and HALT-opcode stop.
module if_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [3:0]  HALT_OP  = 4'hF,
  parameter logic [7:0]  RESET_PC = 8'h00
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     o_imem_req,
  output logic [7:0]               o_imem_addr,
  input  logic [15:0]              i_imem_rdata,
  input  logic                     i_redirect,
  input  logic [7:0]               i_redirect_pc,
  input  logic                     i_stall,
  output logic [15:0]              o_instr_out,
  output logic [7:0]               o_pc_out,
  output logic                     o_valid_out,
  output logic                     o_halt,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [0:0] {StRun, StHalted} state_e;

  state_e        r_state;
  state_e        w_state_next;
  logic [7:0]    r_fetch_pc;
  logic [7:0]    r_req_pc;
  logic          r_inflight;
  logic [15:0]   r_fifo_instr [DEPTH];
  logic [7:0]    r_fifo_pc    [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  logic          w_valid;
  logic          w_push;
  logic          w_pop;
  logic          w_stop_hold;
  logic          w_issue;
  logic [AW+1:0] w_credit;

  assign w_valid     = (r_count != '0);
  // A response arriving in a redirect cycle belongs to the squashed path.
  assign w_push      = r_inflight && !i_redirect;
  assign w_stop_hold = w_push && (i_imem_rdata[15:12] == HALT_OP);
  assign w_pop       = w_valid && !i_stall && !i_redirect;
  // Queued plus in-flight entries; a free slot is reserved for every outstanding request.
  assign w_credit    = {1'b0, r_count} + {{(AW + 1){1'b0}}, r_inflight};
  assign w_issue     = !reset && (r_state == StRun) && !i_redirect && !w_stop_hold &&
                       (w_credit < (AW + 2)'(DEPTH));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StRun;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StRun:    if (w_stop_hold) w_state_next = StHalted;
      StHalted: w_state_next = StHalted;
      default:  w_state_next = StRun;
    endcase
    if (i_redirect) w_state_next = StRun;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= RESET_PC;
      r_inflight <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
    end else if (i_redirect) begin
      r_fetch_pc <= i_redirect_pc;
      r_inflight <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
    end else begin
      if (w_issue) begin
        r_fetch_pc <= r_fetch_pc + 8'd1;
        r_req_pc   <= r_fetch_pc;
      end
      r_inflight <= w_issue;
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW + 1)'(1);
        2'b01:   r_count <= r_count - (AW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the queue is empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_instr[r_wr_ptr] <= i_imem_rdata;
      r_fifo_pc[r_wr_ptr]    <= r_req_pc;
    end
  end

  assign o_imem_req  = w_issue;
  assign o_imem_addr = r_fetch_pc;
  assign o_valid_out = w_valid;
  assign o_instr_out = w_valid ? r_fifo_instr[r_rd_ptr] : 16'h0000;
  assign o_pc_out    = w_valid ? r_fifo_pc[r_rd_ptr] : 8'h00;
  assign o_halt      = (r_state == StHalted);
  assign o_count     = r_count;

endmodule
